uart_rx_param: RTL

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_sync.sv | 22 ++
 rtl/uart_rx_param.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM states, parity modes and
// the bit-period derivation used by every block that needs baud timing.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP,
      WAIT_IDLE
   } uart_state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   function automatic int calc_clks_per_bit(input int clock_freq, input int baudrate);
      return clock_freq / baudrate;
   endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous line that idles high; both
// flops reset to 1 so a reset never looks like a start bit.
module uart_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic sync_out
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta     <= 1'b1;
         sync_out <= 1'b1;
      end else begin
         meta     <= async_in;
         sync_out <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: mid-bit sampling, optional parity, 1 or 2
// stop bits, and a valid/ready output holding register with overrun flag.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 27000000,
   parameter int BAUDRATE   = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CLKS_PER_BIT = calc_clks_per_bit(CLOCK_FREQ, BAUDRATE);
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int IDX_W        = 4;

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

   if (CLOCK_FREQ < 1 || BAUDRATE < 1 || CLKS_PER_BIT < 4 ||
       DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
       STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
      $error("uart_rx_param: illegal parameter combination");
   end

   logic                 rx_s;
   uart_state_t          state, state_nx;
   logic [CNT_W-1:0]     bit_cnt, cnt_nx;
   logic [IDX_W-1:0]     bit_idx, idx_nx;
   logic [DATA_BITS-1:0] shift_reg, shift_nx;
   logic                 frame_acc, frame_nx;
   logic                 par_acc, par_nx;
   logic                 complete;

   uart_sync u_sync (
      .clk      (sys_clk),
      .rst_n    (sys_rst_n),
      .async_in (rx),
      .sync_out (rx_s)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         frame_acc <= 1'b0;
         par_acc   <= 1'b0;
      end else begin
         state     <= state_nx;
         bit_cnt   <= cnt_nx;
         bit_idx   <= idx_nx;
         shift_reg <= shift_nx;
         frame_acc <= frame_nx;
         par_acc   <= par_nx;
      end
   end

   // Data shifts in from the top so the first (LSB) bit ends up at bit 0.
   always_comb begin
      state_nx = state;
      cnt_nx   = bit_cnt;
      idx_nx   = bit_idx;
      shift_nx = shift_reg;
      frame_nx = frame_acc;
      par_nx   = par_acc;
      complete = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_nx = START;
               cnt_nx   = '0;
            end
         end
         START: begin
            if (bit_cnt == HALF_LAST) begin
               cnt_nx   = '0;
               idx_nx   = '0;
               frame_nx = 1'b0;
               par_nx   = 1'b0;
               state_nx = rx_s ? IDLE : DATA;
            end else begin
               cnt_nx = bit_cnt + 1'b1;
            end
         end
         DATA: begin
            if (bit_cnt == BIT_LAST) begin
               cnt_nx   = '0;
               shift_nx = {rx_s, shift_reg[DATA_BITS-1:1]};
               if (bit_idx == DATA_LAST) begin
                  idx_nx   = '0;
                  state_nx = (PARITY != PAR_NONE) ? PAR : STOP;
               end else begin
                  idx_nx = bit_idx + 1'b1;
               end
            end else begin
               cnt_nx = bit_cnt + 1'b1;
            end
         end
         PAR: begin
            if (bit_cnt == BIT_LAST) begin
               cnt_nx   = '0;
               par_nx   = (PARITY == PAR_ODD) ? ~(^{shift_reg, rx_s}) : (^{shift_reg, rx_s});
               state_nx = STOP;
            end else begin
               cnt_nx = bit_cnt + 1'b1;
            end
         end
         STOP: begin
            if (bit_cnt == BIT_LAST) begin
               cnt_nx = '0;
               if (!rx_s) begin
                  frame_nx = 1'b1;
               end
               if (bit_idx == STOP_LAST) begin
                  complete = 1'b1;
                  idx_nx   = '0;
                  state_nx = rx_s ? IDLE : WAIT_IDLE;
               end else begin
                  idx_nx = bit_idx + 1'b1;
               end
            end else begin
               cnt_nx = bit_cnt + 1'b1;
            end
         end
         WAIT_IDLE: begin
            if (rx_s) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // A completed frame is only dropped when the previous word is still unread.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (complete) begin
            if (!rx_valid || rx_ready) begin
               rx_data    <= shift_reg;
               frame_err  <= frame_nx;
               parity_err <= par_acc;
               rx_valid   <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule
